// File: rtl/rx_link_pkg.sv
// Shared types and widths for the RX lane bring-up/recovery sequencer.
package rx_link_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_GT_RST     = 3'd1,
        ST_ALN_RST    = 3'd2,
        ST_WAIT_ALIGN = 3'd3,
        ST_WAIT_UP    = 3'd4,
        ST_LINK_UP    = 3'd5
    } state_t;

    // Largest of the three timed intervals sets the shared timer width.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rx_link_timer.sv
// Shared state timer: synchronous clear, hold when disabled, saturates instead of wrapping.
module rx_link_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic             term_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign term_c = (count == terminal);

endmodule

// File: rtl/rx_link_ctrl.sv
// Bring-up and recovery sequencer for one GT RX lane and its header aligner.
module rx_link_ctrl
    import rx_link_pkg::*;
#(
    parameter int unsigned ALIGN_TIMEOUT = 65536,
    parameter int unsigned UP_TIMEOUT    = 2097152,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned LOSS_FILTER   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               rx_aligned,
    input  logic               rx_up,
    input  logic               gt_rx_reset_done,
    output logic               gt_rx_reset_req,
    output logic               aligner_rst,
    output logic               link_up,
    output logic [STATE_W-1:0] state_o,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  link_loss_cnt
);

    localparam int unsigned TMR_W = $clog2(max3(ALIGN_TIMEOUT, UP_TIMEOUT, RST_CYCLES));
    localparam int unsigned LF_W  = $clog2(LOSS_FILTER + 1);

    state_t             state;
    state_t             state_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [LF_W-1:0]    loss_cnt;
    logic [LF_W-1:0]    loss_nxt;
    logic               do_retry_c;
    logic               loss_evt_c;
    logic               loss_hit_c;
    logic               state_chg_c;
    logic               tmr_en_c;
    logic               tmr_term_c;
    logic [TMR_W-1:0]   tmr_terminal_c;

    assign state_o     = state;
    assign state_chg_c = (state_nxt != state);
    assign loss_hit_c  = !rx_aligned && (loss_cnt == LF_W'(LOSS_FILTER - 1));
    assign tmr_en_c    = (state == ST_ALN_RST) || (state == ST_WAIT_ALIGN) || (state == ST_WAIT_UP);

    // Terminal value for whichever interval the current state is timing.
    always_comb begin
        tmr_terminal_c = TMR_W'(UP_TIMEOUT - 1);
        case (state)
            ST_ALN_RST:    tmr_terminal_c = TMR_W'(RST_CYCLES - 1);
            ST_WAIT_ALIGN: tmr_terminal_c = TMR_W'(ALIGN_TIMEOUT - 1);
            default:       tmr_terminal_c = TMR_W'(UP_TIMEOUT - 1);
        endcase
    end

    rx_link_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_chg_c),
        .en       (tmr_en_c),
        .terminal (tmr_terminal_c),
        .term_c   (tmr_term_c)
    );

    // Next state; priority is enable, then success, then loss, then timeout.
    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        do_retry_c = 1'b0;
        loss_evt_c = 1'b0;

        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_GT_RST;
                end
                ST_GT_RST: begin
                    if (gt_rx_reset_req && gt_rx_reset_done) begin
                        state_nxt = ST_ALN_RST;
                    end
                end
                ST_ALN_RST: begin
                    if (tmr_term_c) begin
                        state_nxt = ST_WAIT_ALIGN;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (rx_aligned) begin
                        state_nxt = ST_WAIT_UP;
                    end else if (tmr_term_c) begin
                        do_retry_c = 1'b1;
                    end
                end
                ST_WAIT_UP: begin
                    if (rx_up) begin
                        state_nxt = ST_LINK_UP;
                    end else if (loss_hit_c || tmr_term_c) begin
                        do_retry_c = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (loss_hit_c) begin
                        loss_evt_c = 1'b1;
                        do_retry_c = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (do_retry_c) begin
            if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
                state_nxt = ST_GT_RST;
            end else begin
                retry_nxt = retry_cnt + RETRY_W'(1);
                state_nxt = ST_ALN_RST;
            end
        end

        if ((state_nxt != state) && ((state_nxt == ST_GT_RST) || (state_nxt == ST_LINK_UP))) begin
            retry_nxt = '0;
        end
    end

    // Consecutive-miss filter on rx_aligned, only meaningful once aligned.
    always_comb begin
        loss_nxt = '0;
        if (!state_chg_c && !rx_aligned &&
            ((state == ST_WAIT_UP) || (state == ST_LINK_UP)) &&
            (loss_cnt != LF_W'(LOSS_FILTER))) begin
            loss_nxt = loss_cnt + LF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            retry_cnt       <= '0;
            loss_cnt        <= '0;
            aligner_rst     <= 1'b1;
            gt_rx_reset_req <= 1'b0;
            link_up         <= 1'b0;
        end else begin
            state           <= state_nxt;
            retry_cnt       <= retry_nxt;
            loss_cnt        <= loss_nxt;
            aligner_rst     <= (state_nxt == ST_IDLE) || (state_nxt == ST_GT_RST) ||
                               (state_nxt == ST_ALN_RST);
            gt_rx_reset_req <= (state_nxt == ST_GT_RST);
            link_up         <= (state_nxt == ST_LINK_UP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_loss_cnt <= '0;
        end else if (loss_evt_c && (link_loss_cnt != '1)) begin
            link_loss_cnt <= link_loss_cnt + LOSS_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Directed bench for rx_link_ctrl with small timeouts and hand-computed expectations.
module tb_rx_link_ctrl;

    localparam int unsigned ALIGN_TIMEOUT = 64;
    localparam int unsigned UP_TIMEOUT    = 256;
    localparam int unsigned RST_CYCLES    = 4;
    localparam int unsigned MAX_RETRY     = 3;
    localparam int unsigned LOSS_FILTER   = 4;

    logic        clk              = 1'b0;
    logic        rst_n            = 1'b0;
    logic        enable           = 1'b0;
    logic        rx_aligned       = 1'b0;
    logic        rx_up            = 1'b0;
    logic        gt_rx_reset_done = 1'b0;
    logic        gt_rx_reset_req;
    logic        aligner_rst;
    logic        link_up;
    logic [2:0]  state_o;
    logic [3:0]  retry_cnt;
    logic [15:0] link_loss_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rx_link_ctrl #(
        .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
        .UP_TIMEOUT    (UP_TIMEOUT),
        .RST_CYCLES    (RST_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .LOSS_FILTER   (LOSS_FILTER)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .rx_aligned       (rx_aligned),
        .rx_up            (rx_up),
        .gt_rx_reset_done (gt_rx_reset_done),
        .gt_rx_reset_req  (gt_rx_reset_req),
        .aligner_rst      (aligner_rst),
        .link_up          (link_up),
        .state_o          (state_o),
        .retry_cnt        (retry_cnt),
        .link_loss_cnt    (link_loss_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n;
        n = 0;
        while ((state_o !== target) && (n < budget)) begin
            step();
            n++;
        end
        checks++;
        if (state_o !== target) begin
            errors++;
            $display("FAIL %s: state_o=%0d required %0d within %0d cycles", tag, state_o, target, budget);
        end
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        enable           = 1'b0;
        rx_aligned       = 1'b0;
        rx_up            = 1'b0;
        gt_rx_reset_done = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic bring_up();
        enable = 1'b1;
        wait_state(3'd1, 5, "bu_gt_rst");
        gt_rx_reset_done = 1'b1;
        wait_state(3'd2, 5, "bu_aln_rst");
        gt_rx_reset_done = 1'b0;
        wait_state(3'd3, 10, "bu_wait_align");
        rx_aligned = 1'b1;
        wait_state(3'd4, 5, "bu_wait_up");
        rx_up = 1'b1;
        wait_state(3'd5, 5, "bu_link_up");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({state_o, aligner_rst, gt_rx_reset_req, link_up} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d arst=%b req=%b up=%b required 0 1 0 0",
                     state_o, aligner_rst, gt_rx_reset_req, link_up);
        end
        checks++;
        if ({retry_cnt, link_loss_cnt} !== 20'd0) begin
            errors++;
            $display("FAIL reset_cnt: retry=%0d loss=%0d required 0 0", retry_cnt, link_loss_cnt);
        end
    endtask

    task automatic test_nominal();
        int n;
        apply_reset();
        enable = 1'b1;
        step();
        checks++;
        if ({state_o, gt_rx_reset_req, aligner_rst} !== {3'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL nom_gt_rst: state=%0d req=%b arst=%b required 1 1 1", state_o, gt_rx_reset_req, aligner_rst);
        end
        repeat (2) step();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL nom_gt_hold: state=%0d required 1", state_o);
        end
        gt_rx_reset_done = 1'b1;
        step();
        gt_rx_reset_done = 1'b0;
        checks++;
        if ({state_o, gt_rx_reset_req} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL nom_aln_rst: state=%0d req=%b required 2 0", state_o, gt_rx_reset_req);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (state_o !== 3'd2) break;
            if (aligner_rst === 1'b1) n++;
            step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL nom_arst_len: aligner_rst cycles=%0d required 4", n);
        end
        checks++;
        if ({state_o, aligner_rst} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL nom_wait_align: state=%0d arst=%b required 3 0", state_o, aligner_rst);
        end
        repeat (10) step();
        rx_aligned = 1'b1;
        step();
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL nom_wait_up: state=%0d required 4", state_o);
        end
        repeat (50) step();
        checks++;
        if ({state_o, link_up} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL nom_up_hold: state=%0d up=%b required 4 0", state_o, link_up);
        end
        rx_up = 1'b1;
        step();
        checks++;
        if ({state_o, link_up, retry_cnt} !== {3'd5, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL nom_link_up: state=%0d up=%b retry=%0d required 5 1 0", state_o, link_up, retry_cnt);
        end
    endtask

    task automatic test_align_timeout();
        int n;
        logic [2:0] exp_state [3];
        logic [3:0] exp_retry [3];
        exp_state = '{3'd2, 3'd2, 3'd1};
        exp_retry = '{4'd1, 4'd2, 4'd0};
        apply_reset();
        enable = 1'b1;
        wait_state(3'd1, 5, "to_gt_rst");
        gt_rx_reset_done = 1'b1;
        wait_state(3'd2, 5, "to_aln_rst");
        gt_rx_reset_done = 1'b0;
        for (int r = 0; r < 3; r++) begin
            wait_state(3'd3, 10, "to_enter_wait");
            n = 1;
            for (int i = 0; i < 200; i++) begin
                step();
                if (state_o !== 3'd3) break;
                n++;
            end
            checks++;
            if (n != 64) begin
                errors++;
                $display("FAIL to_len[%0d]: wait_align cycles=%0d required 64", r, n);
            end
            checks++;
            if ({state_o, retry_cnt} !== {exp_state[r], exp_retry[r]}) begin
                errors++;
                $display("FAIL to_next[%0d]: state=%0d retry=%0d required %0d %0d",
                         r, state_o, retry_cnt, exp_state[r], exp_retry[r]);
            end
        end
        checks++;
        if (gt_rx_reset_req !== 1'b1) begin
            errors++;
            $display("FAIL to_gt_req: req=%b required 1", gt_rx_reset_req);
        end
    endtask

    task automatic test_loss_filter();
        apply_reset();
        bring_up();
        rx_aligned = 1'b0;
        repeat (3) step();
        rx_aligned = 1'b1;
        step();
        checks++;
        if ({state_o, link_up, link_loss_cnt} !== {3'd5, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL loss3: state=%0d up=%b loss=%0d required 5 1 0", state_o, link_up, link_loss_cnt);
        end
        rx_aligned = 1'b0;
        repeat (3) step();
        checks++;
        if ({state_o, link_up} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL loss4_pre: state=%0d up=%b required 5 1", state_o, link_up);
        end
        step();
        rx_aligned = 1'b1;
        checks++;
        if ({state_o, link_up, aligner_rst, retry_cnt, link_loss_cnt} !== {3'd2, 1'b0, 1'b1, 4'd1, 16'd1}) begin
            errors++;
            $display("FAIL loss4: state=%0d up=%b arst=%b retry=%0d loss=%0d required 2 0 1 1 1",
                     state_o, link_up, aligner_rst, retry_cnt, link_loss_cnt);
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1;
        wait_state(3'd1, 5, "en_gt_rst");
        gt_rx_reset_done = 1'b1;
        wait_state(3'd2, 5, "en_aln_rst");
        gt_rx_reset_done = 1'b0;
        wait_state(3'd3, 10, "en_wait_align");
        rx_aligned = 1'b1;
        wait_state(3'd4, 5, "en_wait_up");
        enable = 1'b0;
        rx_up  = 1'b1;
        step();
        checks++;
        if ({state_o, aligner_rst, link_up} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL en_drop_wait_up: state=%0d arst=%b up=%b required 0 1 0", state_o, aligner_rst, link_up);
        end
        apply_reset();
        bring_up();
        enable = 1'b0;
        step();
        checks++;
        if ({state_o, aligner_rst, link_up} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL en_drop_link_up: state=%0d arst=%b up=%b required 0 1 0", state_o, aligner_rst, link_up);
        end
        repeat (2) step();
        checks++;
        if ({state_o, gt_rx_reset_req} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL en_hold_idle: state=%0d req=%b required 0 0", state_o, gt_rx_reset_req);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        enable = 1'b1;
        wait_state(3'd1, 5, "sim_gt_rst");
        gt_rx_reset_done = 1'b1;
        wait_state(3'd2, 5, "sim_aln_rst");
        gt_rx_reset_done = 1'b0;
        wait_state(3'd3, 10, "sim_wait1");
        wait_state(3'd2, 70, "sim_retry1");
        wait_state(3'd3, 10, "sim_wait2");
        repeat (63) step();
        checks++;
        if ({state_o, retry_cnt} !== {3'd3, 4'd1}) begin
            errors++;
            $display("FAIL sim_pre: state=%0d retry=%0d required 3 1", state_o, retry_cnt);
        end
        rx_aligned = 1'b1;
        step();
        checks++;
        if ({state_o, retry_cnt} !== {3'd4, 4'd1}) begin
            errors++;
            $display("FAIL sim_success: state=%0d retry=%0d required 4 1", state_o, retry_cnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bring_up();
        rx_aligned = 1'b0;
        repeat (4) step();
        rx_aligned = 1'b1;
        wait_state(3'd5, 20, "ar_relink");
        checks++;
        if (link_loss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ar_pre: loss=%0d required 1", link_loss_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_o, aligner_rst, gt_rx_reset_req, link_up, retry_cnt, link_loss_cnt} !==
            {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0}) begin
            errors++;
            $display("FAIL ar_mid: state=%0d arst=%b req=%b up=%b retry=%0d loss=%0d required 0 1 0 0 0 0",
                     state_o, aligner_rst, gt_rx_reset_req, link_up, retry_cnt, link_loss_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        bring_up();
        force dut.link_loss_cnt = 16'hFFFF;
        step();
        release dut.link_loss_cnt;
        step();
        rx_aligned = 1'b0;
        repeat (4) step();
        rx_aligned = 1'b1;
        checks++;
        if ({state_o, link_loss_cnt} !== {3'd2, 16'hFFFF}) begin
            errors++;
            $display("FAIL sat: state=%0d loss=%h required 2 ffff", state_o, link_loss_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_align_timeout();
        test_loss_filter();
        test_enable_drop();
        test_simultaneous();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
